// File: rtl/fcp_rx_ctrl.sv
// fcp_rx_ctrl: single-wire FCP receiver.
// Synchronizes the raw line and recovers bit timing from its edges. It
// separates ping events (long silences) from data bytes. A data byte is
// 8 bits MSB first followed by an odd parity bit.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous reset, active-high
//   i_din          raw FCP line (asynchronous)
//   i_tune_up      1: UI = UI_CYCLE + i_tune_cycle, 0: UI = UI_CYCLE - i_tune_cycle
//   i_tune_cycle   UI adjustment in clocks
//   o_rx_byte      last committed byte
//   o_rx_byte_vld  1-cycle pulse when o_rx_byte / o_rx_par_err update
//   o_rx_par_err   parity result for o_rx_byte (1 = bad)
//   o_rx_ping      1-cycle pulse on a valid ping end edge
//   o_rx_byte_cnt  bytes committed since last ping/reset, saturates at 15
//   o_rx_err       1-cycle pulse on a framing/timeout error
//   o_rx_busy      receiver not idle
//
// Optional build macro FCP_RX_GLITCH_FILTER_EN inserts a 3-tap stability
// filter after the synchronizer. The filter suppresses 1-2 clk pulses and
// adds 2 clk of latency to every edge.
module fcp_rx_ctrl #(
  parameter int unsigned UI_CYCLE    = 20,
  parameter int unsigned SYNC_MIN    = 2,
  parameter int unsigned PING_MIN_UI = 12,
  parameter int unsigned PING_MAX_UI = 24
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_din,
  input  logic       i_tune_up,
  input  logic [7:0] i_tune_cycle,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_byte_vld,
  output logic       o_rx_par_err,
  output logic       o_rx_ping,
  output logic [3:0] o_rx_byte_cnt,
  output logic       o_rx_err,
  output logic       o_rx_busy
);

  localparam int unsigned TW = 16;
  localparam int unsigned DW = 8;
  localparam logic [1:0]  SYNC_MIN_C = 2'(SYNC_MIN);
  localparam logic [3:0]  LAST_SMP   = 4'(DW);   // bit count before the parity sample

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_PAR_WAIT,
    S_PING_CHK
  } state_t;

  state_t r_state, w_state_nxt;

  // ---------------- input path ----------------
  logic r_sync1, r_sync2, r_dly;
  logic w_level, w_edge;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_dly   <= 1'b0;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
      r_dly   <= w_level;
    end
  end

`ifdef FCP_RX_GLITCH_FILTER_EN
  // Level follows the synchronizer only after three equal consecutive samples.
  logic [1:0] r_hist;
  logic       r_filt;

  always_comb begin
    w_level = r_filt;
    if ((r_sync2 == r_hist[0]) && (r_hist[0] == r_hist[1])) w_level = r_sync2;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hist <= 2'b00;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
      r_filt <= w_level;
    end
  end
`else
  always_comb w_level = r_sync2;
`endif

  assign w_edge = w_level ^ r_dly;

  // ---------------- timing references ----------------
  logic [TW-1:0] w_ui, w_half, w_qtr_max, w_min_gap, w_ping_min, w_ping_max;

  always_comb begin
    w_ui       = i_tune_up ? (TW'(UI_CYCLE) + TW'(i_tune_cycle))
                           : (TW'(UI_CYCLE) - TW'(i_tune_cycle));
    w_half     = w_ui >> 1;
    w_qtr_max  = w_half;
    w_min_gap  = w_ui >> 3;
    w_ping_min = TW'(PING_MIN_UI) * w_ui;
    w_ping_max = TW'(PING_MAX_UI) * w_ui;
  end

  // Silence / sample counters; both read 1 in the cycle after a restart.
  logic [TW-1:0] r_sil, r_smp;
  logic          r_from_edge;   // last smp restart came from an edge
  logic          w_sample;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sil       <= '0;
      r_smp       <= '0;
      r_from_edge <= 1'b0;
    end else begin
      if (w_edge)            r_sil <= TW'(1);
      else if (r_sil != '1)  r_sil <= r_sil + TW'(1);

      if (w_edge || w_sample) r_smp <= TW'(1);
      else if (r_smp != '1)   r_smp <= r_smp + TW'(1);

      if (w_edge)        r_from_edge <= 1'b1;
      else if (w_sample) r_from_edge <= 1'b0;
    end
  end

  // ---------------- FSM ----------------
  logic [1:0] r_sync_cnt;
  logic [3:0] r_bit_cnt;
  logic [8:0] r_shift;
  logic       w_first, w_commit, w_ping, w_err, w_sync_clr, w_sync_inc;
  logic       w_smp_due;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sample    = 1'b0;
    w_first     = 1'b0;
    w_commit    = 1'b0;
    w_ping      = 1'b0;
    w_err       = 1'b0;
    w_sync_clr  = 1'b0;
    w_sync_inc  = 1'b0;
    w_smp_due   = r_from_edge ? (r_smp >= w_half) : (r_smp >= w_ui);

    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_state_nxt = S_SYNC;
          w_sync_clr  = 1'b1;
        end
      end
      S_SYNC: begin
        if (w_edge) begin
          if (r_sil <= w_qtr_max) begin
            w_sync_inc = 1'b1;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (r_sil >= w_half) begin
          if (r_sync_cnt >= SYNC_MIN_C) begin
            // Bit 7 is sampled in the same cycle as the state change.
            w_state_nxt = S_DATA;
            w_sample    = 1'b1;
            w_first     = 1'b1;
          end else begin
            w_state_nxt = S_PING_CHK;
          end
        end
      end
      S_DATA: begin
        if (w_edge && (r_sil < w_min_gap)) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_smp_due) begin
          w_sample = 1'b1;
          if (r_bit_cnt == LAST_SMP) w_state_nxt = S_PAR_WAIT;
        end
      end
      S_PAR_WAIT: begin
        if (w_edge) begin
          // Closing edge commits the byte and opens the next sync window.
          w_commit    = 1'b1;
          w_sync_clr  = 1'b1;
          w_state_nxt = S_SYNC;
        end else if (r_smp >= w_ui) begin
          w_state_nxt = S_PING_CHK;
        end
      end
      S_PING_CHK: begin
        if (w_edge) begin
          if (r_sil >= w_ping_min) begin
            w_ping      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_err       = 1'b1;
            w_sync_clr  = 1'b1;
            w_state_nxt = S_SYNC;
          end
        end else if (r_sil > w_ping_max) begin
          w_err       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- datapath and registered outputs ----------------
  logic [7:0] r_byte;
  logic       r_vld, r_par_err, r_ping, r_err, r_busy;
  logic [3:0] r_byte_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_byte     <= '0;
      r_vld      <= 1'b0;
      r_par_err  <= 1'b0;
      r_ping     <= 1'b0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      if (w_sync_clr)                          r_sync_cnt <= '0;
      else if (w_sync_inc && r_sync_cnt != '1) r_sync_cnt <= r_sync_cnt + 2'(1);

      // r_dly is the level before any edge seen this cycle.
      if (w_sample) begin
        r_shift   <= {r_shift[7:0], r_dly};
        r_bit_cnt <= w_first ? 4'd1 : (r_bit_cnt + 4'd1);
      end

      r_vld  <= w_commit;
      r_ping <= w_ping;
      r_err  <= w_err;
      r_busy <= (w_state_nxt != S_IDLE);

      if (w_commit) begin
        r_byte    <= r_shift[8:1];
        r_par_err <= (r_shift[0] != ~^r_shift[8:1]);
        if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 4'd1;
      end else if (w_ping) begin
        r_byte_cnt <= '0;
      end
    end
  end

  assign o_rx_byte     = r_byte;
  assign o_rx_byte_vld = r_vld;
  assign o_rx_par_err  = r_par_err;
  assign o_rx_ping     = r_ping;
  assign o_rx_byte_cnt = r_byte_cnt;
  assign o_rx_err      = r_err;
  assign o_rx_busy     = r_busy;

endmodule

// File: doc/fcp_rx_ctrl.md
Name: fcp_rx_ctrl

Overview:
- Single-wire FCP receiver.
- Consumes the line driven by the TX controller: synchronizes it, recovers the bit timing from edges, and splits traffic into ping events and data bytes (8 data bits MSB first, plus odd parity).
- Decoded bytes and ping events go to the protocol/message layer; UI tuning matches the transmitter.

Parameters:
- UI_CYCLE, 20, nominal clocks per UI.
- SYNC_MIN, 2, minimum quarter-UI sync edges (after the entry edge) before a data byte is accepted.
- PING_MIN_UI, 12, minimum silent UIs that qualify as a ping.
- PING_MAX_UI, 24, silence longer than this is a timeout error.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- din  in  1  raw FCP line (asynchronous)
- tune_up  in  1  1: UI = UI_CYCLE+tune_cycle; 0: UI = UI_CYCLE-tune_cycle
- tune_cycle  in  8  UI adjustment
- rx_byte  out  8  last committed byte
- rx_byte_vld  out  1  1-cycle pulse when rx_byte and rx_par_err update
- rx_par_err  out  1  parity result for rx_byte (1 = bad)
- rx_ping  out  1  1-cycle pulse on a valid ping end edge
- rx_byte_cnt  out  4  bytes committed since last ping/reset, saturates at 15
- rx_err  out  1  1-cycle pulse on a framing/timeout error
- rx_busy  out  1  state != IDLE

Behaviour:
- Reset: rst is synchronous and active-high. While rst=1 every output is 0 and the FSM is in IDLE; the synchronizer flops, counters and shift register clear. Reset mid-byte discards the partial byte with no pulse.
- Input path: 2-flop synchronizer, then a delay flop. edge = sync ^ delayed. The first edge is visible 3 clk after a din change.
- UI width = tuned value (16-bit). HALF = UI>>1. QTR_MAX = HALF.
- sil_cnt: 16-bit, cleared to 1 on each edge, increments otherwise, saturates at 0xFFFF.
- smp_cnt: cleared on each edge and on each sample.
- FSM states: IDLE, SYNC, DATA, PAR_WAIT, PING_CHK.
- IDLE:
  - edge -> SYNC, sync_cnt=0.
- SYNC:
  - Edge with sil_cnt <= QTR_MAX -> sync_cnt++ (saturates at 3).
  - sil_cnt reaches HALF with no edge:
    - sync_cnt >= SYNC_MIN -> DATA. The first sample (bit7) is taken in this same cycle.
    - otherwise -> PING_CHK.
- DATA:
  - Sample when smp_cnt reaches HALF after an edge, or UI after the previous sample. Edges resynchronize.
  - Nine samples are shifted MSB first: 8 data bits, then parity.
  - After the 9th sample -> PAR_WAIT.
- PAR_WAIT (byte pending):
  - Edge within UI after the parity sample:
    - Commit: rx_byte_vld=1 the next cycle.
    - rx_par_err = (parity != ~^data), i.e. odd parity.
    - rx_byte_cnt++.
    - -> SYNC with sync_cnt=0; this edge counts as the sync entry edge.
  - No edge for UI -> discard the byte (no pulse) and go to PING_CHK. This covers an all-constant byte followed by a ping.
- PING_CHK (silence measured from the last edge, sil_cnt is not reset):
  - Edge with sil_cnt >= PING_MIN_UI*UI -> rx_ping pulse, rx_byte_cnt=0, -> IDLE.
  - Edge earlier than that -> rx_err, -> SYNC (treated as a new entry edge).
  - sil_cnt > PING_MAX_UI*UI -> rx_err, -> IDLE.
- SYNC/DATA edge-width violation: an edge in SYNC with QTR_MAX < sil_cnt < HALF is impossible by construction. An edge in DATA closer than UI/8 to the previous edge -> rx_err, -> IDLE.
- Simultaneous events: an edge and a sample in the same cycle -> the sample is taken from the pre-edge level, then the timers restart.
- Outputs are registered. rx_byte, rx_par_err and rx_byte_cnt hold their values between pulses.
- tune_up and tune_cycle are sampled continuously; they must be stable while rx_busy=1.

Optional Feature:
- FCP_RX_GLITCH_FILTER_EN defined:
  - A 3-tap stability filter follows the synchronizer. The filtered level changes only after 3 equal consecutive samples.
  - Pulses of 1-2 clk are suppressed.
  - Adds 2 clk latency to all edges; relative timing is unchanged.
- Undefined: no filter; every synchronized transition is an edge.

Test Plan:
- Standalone ping: UI=20. Toggle din, hold 320 clk, toggle. -> exactly one rx_ping about 3 clk after the second toggle; rx_byte_vld never fires; rx_byte_cnt=0; rx_err=0.
- Byte 0xA5: entry edge plus 2 edges at 5-clk spacing, bits 1,0,1,0,0,1,0,1, parity 1 (20 clk each), then a sync edge. -> rx_byte_vld once, rx_byte=8'hA5, rx_par_err=0, rx_byte_cnt=1.
- Same as the 0xA5 case with parity 0. -> rx_byte=8'hA5, rx_par_err=1.
- Byte 0xFF with parity 1 (constant level with the last sync level), then the line held until 16 UI total, then toggle. -> no rx_byte_vld, one rx_ping, rx_byte_cnt=0.
- Tuned UI: tune_up=1, tune_cycle=4 (UI=24). Two bytes 0x3C, 0x81, each with correct parity, then a 16-UI ping. -> two rx_byte_vld pulses with 3C and 81, rx_byte_cnt reaches 2, then rx_ping and rx_byte_cnt=0. With FCP_RX_GLITCH_FILTER_EN, a 1-clk spike injected mid-bit leaves the bytes unchanged.
- rst=1 asserted for 1 clk after the 4th data bit of a byte. -> all outputs 0 the next cycle, no pulses; the following well-formed byte 0x12 decodes correctly.
